a2d_conv_sched: RTL and testbench

- Conversion scheduler that sequences the shared 16-bit SPI master in front of the ADC128S.
- Runs periodic round-robin sweeps over four mapped ADC channels (battery, current, brake, torque).
- Arbitrates one-shot host conversion requests into the same master.
- Each conversion is two SPI transactions: an address frame, then a read frame. Results are held in per-channel registers with update strobes.

---
 rtl/a2d_conv_sched.sv | 245 ++++++++++++++++++++++++
 tb/tb_a2d_conv_sched.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/a2d_conv_sched.sv
// a2d_conv_sched: sequences the shared 16-bit SPI master in front of an
// ADC128S. Periodic round-robin sweeps over four mapped channels share the
// master with one-shot host requests. Each conversion is an address frame
// followed, after a short idle gap, by a read frame with the same command word.
module a2d_conv_sched #(
    parameter logic [2:0] CH0     = 3'd0,
    parameter logic [2:0] CH1     = 3'd1,
    parameter logic [2:0] CH2     = 3'd3,
    parameter logic [2:0] CH3     = 3'd4,
    parameter int         PERIOD  = 16384,
    parameter int         GAP_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  en_mask,
    input  logic        mstr_done,
    input  logic [15:0] mstr_resp,
    output logic        mstr_wrt,
    output logic [15:0] mstr_cmd,
    input  logic        hreq,
    input  logic [2:0]  hchnl,
    output logic        hack,
    output logic [11:0] hdata,
    output logic [11:0] res0,
    output logic [11:0] res1,
    output logic [11:0] res2,
    output logic [11:0] res3,
    output logic [3:0]  res_vld,
    output logic        sweep_done,
    output logic        ovr
);

    localparam int CNT_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_READ = 2'd3;

    // Both frames of a conversion carry the channel in bits [13:11].
    function automatic logic [15:0] make_cmd(input logic [2:0] ch);
        return {2'b00, ch, 11'h000};
    endfunction

    // Lowest-numbered enabled slot; disabled slots cost no cycles.
    function automatic logic [1:0] first_slot(input logic [3:0] m);
        logic [1:0] s;
        s = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) s = 2'(i);
        end
        return s;
    endfunction

    function automatic logic [2:0] slot_chnl(input logic [1:0] s);
        logic [2:0] c;
        case (s)
            2'd0:    c = CH0;
            2'd1:    c = CH1;
            2'd2:    c = CH2;
            default: c = CH3;
        endcase
        return c;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             active_q, active_d;
    logic [3:0]       rem_q, rem_d;
    logic [1:0]       slot_q, slot_d;
    logic             job_host_q, job_host_d;
    logic             last_host_q, last_host_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             wrt_q, wrt_d;
    logic [15:0]      cmd_q, cmd_d;
    logic             hack_q, hack_d;
    logic [11:0]      hdata_q, hdata_d;
    logic [11:0]      res_q [4];
    logic [11:0]      res_d [4];
    logic [3:0]       vld_q, vld_d;
    logic             sd_q, sd_d;
    logic             ovr_q, ovr_d;

    logic       tc, host_pend, sweep_work, pick_host, pick_sweep, start;
    logic       done_cap, sweep_fin, busy;
    logic [3:0] cand;
    logic [1:0] sel;
    logic       unused_resp;

    assign unused_resp = ^mstr_resp[15:12];

    assign tc         = (cnt_q == CNT_W'(PERIOD - 1));
    // hreq is still high during the hack cycle; it only counts again afterwards.
    assign host_pend  = hreq & ~hack_q;
    assign sweep_work = pend_q | (rem_q != 4'd0);
    assign pick_host  = (state_q == S_IDLE) & host_pend & (~sweep_work | ~last_host_q);
    assign pick_sweep = (state_q == S_IDLE) & sweep_work & ~pick_host;
    assign start      = pick_sweep & (rem_q == 4'd0);
    assign cand       = start ? en_mask : rem_q;
    assign sel        = first_slot(cand);
    assign done_cap   = (state_q == S_READ) & mstr_done;
    // A sweep finishing in the same cycle as terminal count is no longer active.
    assign sweep_fin  = done_cap & ~job_host_q & (rem_q == 4'd0);
    assign busy       = (pend_q | active_q) & ~sweep_fin;

    // Next-state logic: arbitration, conversion sequencing and interval timing.
    always_comb begin
        state_d     = state_q;
        cnt_d       = tc ? '0 : cnt_q + CNT_W'(1);
        pend_d      = pend_q;
        active_d    = active_q;
        rem_d       = rem_q;
        slot_d      = slot_q;
        job_host_d  = job_host_q;
        last_host_d = last_host_q;
        gap_d       = gap_q;
        wrt_d       = 1'b0;
        cmd_d       = cmd_q;
        hack_d      = 1'b0;
        hdata_d     = hdata_q;
        res_d       = res_q;
        vld_d       = 4'd0;
        sd_d        = 1'b0;
        ovr_d       = ovr_q;

        case (state_q)
            S_IDLE: begin
                if (pick_host) begin
                    job_host_d  = 1'b1;
                    last_host_d = 1'b1;
                    cmd_d       = make_cmd(hchnl);
                    wrt_d       = 1'b1;
                    state_d     = S_ADDR;
                end else if (pick_sweep) begin
                    last_host_d = 1'b0;
                    if (start) begin
                        pend_d   = 1'b0;
                        active_d = (en_mask != 4'd0);
                        sd_d     = (en_mask == 4'd0);
                    end
                    if (cand != 4'd0) begin
                        job_host_d = 1'b0;
                        slot_d     = sel;
                        rem_d      = cand & ~(4'b0001 << sel);
                        cmd_d      = make_cmd(slot_chnl(sel));
                        wrt_d      = 1'b1;
                        state_d    = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (mstr_done) begin
                    gap_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(GAP_CYC - 1)) begin
                    wrt_d   = 1'b1;
                    state_d = S_READ;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                if (mstr_done) begin
                    state_d = S_IDLE;
                    if (job_host_q) begin
                        hdata_d = mstr_resp[11:0];
                        hack_d  = 1'b1;
                    end else begin
                        res_d[slot_q] = mstr_resp[11:0];
                        vld_d[slot_q] = 1'b1;
                        if (rem_q == 4'd0) begin
                            sd_d     = 1'b1;
                            active_d = 1'b0;
                        end
                    end
                end
            end
        endcase

        // Terminal count queues at most one sweep; anything more is an overrun.
        if (tc) begin
            if (busy) ovr_d  = 1'b1;
            else      pend_d = 1'b1;
        end
    end

    // State and output registers; reset abandons any in-flight conversion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            active_q    <= 1'b0;
            rem_q       <= 4'd0;
            slot_q      <= 2'd0;
            job_host_q  <= 1'b0;
            last_host_q <= 1'b0;
            gap_q       <= '0;
            wrt_q       <= 1'b0;
            cmd_q       <= 16'd0;
            hack_q      <= 1'b0;
            hdata_q     <= 12'd0;
            for (int i = 0; i < 4; i++) res_q[i] <= 12'd0;
            vld_q       <= 4'd0;
            sd_q        <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            active_q    <= active_d;
            rem_q       <= rem_d;
            slot_q      <= slot_d;
            job_host_q  <= job_host_d;
            last_host_q <= last_host_d;
            gap_q       <= gap_d;
            wrt_q       <= wrt_d;
            cmd_q       <= cmd_d;
            hack_q      <= hack_d;
            hdata_q     <= hdata_d;
            for (int i = 0; i < 4; i++) res_q[i] <= res_d[i];
            vld_q       <= vld_d;
            sd_q        <= sd_d;
            ovr_q       <= ovr_d;
        end
    end

    assign mstr_wrt   = wrt_q;
    assign mstr_cmd   = cmd_q;
    assign hack       = hack_q;
    assign hdata      = hdata_q;
    assign res0       = res_q[0];
    assign res1       = res_q[1];
    assign res2       = res_q[2];
    assign res3       = res_q[3];
    assign res_vld    = vld_q;
    assign sweep_done = sd_q;
    assign ovr        = ovr_q;

endmodule

// File: tb/tb_a2d_conv_sched.sv
// Directed bench for a2d_conv_sched: instance A (PERIOD=64, GAP_CYC=3, fast
// SPI model) covers sweeps, host arbitration, gap timing and reset; instance B
// (PERIOD=8, slow SPI model) covers overrun.
module tb_a2d_conv_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Instance A signals
    logic        rst;
    logic [3:0]  en_a;
    logic        done_a = 1'b0;
    logic [15:0] resp_a = 16'd0;
    logic        wrt_a;
    logic [15:0] cmd_a;
    logic        hreq_a;
    logic [2:0]  hchnl_a;
    logic        hack_a;
    logic [11:0] hdata_a, r0_a, r1_a, r2_a, r3_a;
    logic [3:0]  vld_a;
    logic        sd_a, ovr_a;

    // Instance B signals
    logic        rst_b;
    logic [3:0]  en_b;
    logic        done_b = 1'b0;
    logic [15:0] resp_b = 16'd0;
    logic        wrt_b;
    logic [15:0] cmd_b;
    logic        hreq_b;
    logic [2:0]  hchnl_b;
    logic        hack_b;
    logic [11:0] hdata_b, r0_b, r1_b, r2_b, r3_b;
    logic [3:0]  vld_b;
    logic        sd_b, ovr_b;

    a2d_conv_sched #(.PERIOD(64), .GAP_CYC(3)) u_a (
        .clk(clk), .rst(rst), .en_mask(en_a), .mstr_done(done_a), .mstr_resp(resp_a),
        .mstr_wrt(wrt_a), .mstr_cmd(cmd_a), .hreq(hreq_a), .hchnl(hchnl_a),
        .hack(hack_a), .hdata(hdata_a), .res0(r0_a), .res1(r1_a), .res2(r2_a),
        .res3(r3_a), .res_vld(vld_a), .sweep_done(sd_a), .ovr(ovr_a)
    );

    a2d_conv_sched #(.PERIOD(8), .GAP_CYC(2)) u_b (
        .clk(clk), .rst(rst_b), .en_mask(en_b), .mstr_done(done_b), .mstr_resp(resp_b),
        .mstr_wrt(wrt_b), .mstr_cmd(cmd_b), .hreq(hreq_b), .hchnl(hchnl_b),
        .hack(hack_b), .hdata(hdata_b), .res0(r0_b), .res1(r1_b), .res2(r2_b),
        .res3(r3_b), .res_vld(vld_b), .sweep_done(sd_b), .ovr(ovr_b)
    );

    // SPI master model A (done 2 cycles after wrt) plus output monitors
    logic [15:0] log_a [64];
    logic [3:0]  vlog  [64];
    logic [11:0] data_a = 12'd0;
    int nwrt_a = 0, cnt_a = 0, neg_a = 0, dneg_a = 0, gap_a = -1;
    int vld_n = 0, sd_cnt = 0, hack_cnt = 0;
    bit rd_a = 1'b0, par_a = 1'b0;

    always @(negedge clk) begin
        neg_a++;
        done_a = 1'b0;
        if (rst) par_a = 1'b0;
        if (wrt_a) begin
            if (nwrt_a < 64) log_a[nwrt_a] = cmd_a;
            nwrt_a++;
            rd_a = par_a;
            if (par_a) gap_a = neg_a - dneg_a - 1;
            par_a = ~par_a;
            cnt_a = 2;
        end else if (cnt_a > 0) begin
            cnt_a--;
            if (cnt_a == 0) begin
                done_a = 1'b1;
                resp_a = rd_a ? {4'hC, data_a} : 16'h0FFF;
                if (!rd_a) dneg_a = neg_a;
            end
        end
        if (vld_a != 4'd0) begin
            if (vld_n < 64) vlog[vld_n] = vld_a;
            vld_n++;
        end
        if (sd_a) sd_cnt++;
        if (hack_a) hack_cnt++;
    end

    // SPI master model B (slow: done 20 cycles after wrt)
    int nwrt_b = 0, cnt_b = 0, sd_cnt_b = 0;
    always @(negedge clk) begin
        done_b = 1'b0;
        if (wrt_b) begin
            nwrt_b++;
            cnt_b = 20;
        end else if (cnt_b > 0) begin
            cnt_b--;
            if (cnt_b == 0) begin
                done_b = 1'b1;
                resp_b = 16'h0123;
            end
        end
        if (sd_b) sd_cnt_b++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_sd_a(input string tag);
        for (int k = 0; k < 200; k++) begin
            tick();
            if (sd_a) break;
        end
        chk(tag, 64'(sd_a), 1);
    endtask

    task automatic wait_nwrt_a(input string tag, input int n);
        for (int k = 0; k < 200; k++) begin
            if (nwrt_a >= n) break;
            tick();
        end
        chk(tag, 64'(nwrt_a >= n), 1);
    endtask

    logic [15:0] exp8  [8]  = '{16'h0000, 16'h0000, 16'h0800, 16'h0800,
                                16'h1800, 16'h1800, 16'h2000, 16'h2000};
    logic [15:0] exp10 [10] = '{16'h0000, 16'h0000, 16'h0800, 16'h0800, 16'h3800,
                                16'h3800, 16'h1800, 16'h1800, 16'h2000, 16'h2000};

    initial begin
        int base, vb, sdb, hb, vc, hc;
        rst = 1'b1; rst_b = 1'b1;
        en_a = 4'b0101; hreq_a = 1'b0; hchnl_a = 3'd0;
        en_b = 4'hF;    hreq_b = 1'b0; hchnl_b = 3'd0;
        data_a = 12'h5A5;
        repeat (3) tick();
        chk("rst_ctrl", 64'({wrt_a, hack_a, sd_a, ovr_a, vld_a}), 0);
        chk("rst_cmd", 64'(cmd_a), 0);
        chk("rst_data", 64'({hdata_a, r0_a, r1_a, r2_a, r3_a}), 0);
        rst = 1'b0;

        // Masked sweep 0101
        wait_sd_a("sd_mask");
        chk("mask_res0", 64'(r0_a), 'h5A5);
        chk("mask_res1", 64'(r1_a), 0);
        chk("mask_res2", 64'(r2_a), 'h5A5);
        chk("mask_res3", 64'(r3_a), 0);
        chk("mask_nwrt", 64'(nwrt_a), 4);
        chk("mask_cmd2", 64'(log_a[2]), 'h1800);
        chk("mask_cmd3", 64'(log_a[3]), 'h1800);
        chk("mask_vld", 64'({vlog[0], vlog[1]}), 'h14);

        // Full sweep
        en_a = 4'hF; data_a = 12'hABC;
        base = nwrt_a; vb = vld_n; sdb = sd_cnt;
        wait_sd_a("sd_full");
        tick(); tick();
        for (int i = 0; i < 8; i++) chk($sformatf("full_cmd%0d", i), 64'(log_a[base + i]), 64'(exp8[i]));
        chk("full_nwrt", 64'(nwrt_a - base), 8);
        chk("full_res", 64'({r0_a, r1_a, r2_a, r3_a}), 'hABCABCABCABC);
        chk("full_vld", 64'({vlog[vb], vlog[vb + 1], vlog[vb + 2], vlog[vb + 3]}), 'h1248);
        chk("full_sdcnt", 64'(sd_cnt - sdb), 1);
        chk("gap_cycles", 64'(gap_a), 3);

        // Empty sweep
        en_a = 4'h0;
        base = nwrt_a;
        wait_sd_a("sd_empty");
        tick(); tick();
        chk("empty_nwrt", 64'(nwrt_a - base), 0);

        // Host request mid slot 1
        en_a = 4'hF; data_a = 12'h777;
        base = nwrt_a; hb = hack_cnt;
        wait_nwrt_a("host_slot1", base + 3);
        hreq_a = 1'b1; hchnl_a = 3'd7;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (hack_a) break;
        end
        chk("host_hack", 64'(hack_a), 1);
        chk("host_hdata", 64'(hdata_a), 'h777);
        hreq_a = 1'b0;
        wait_sd_a("sd_host");
        tick(); tick();
        for (int i = 0; i < 10; i++) chk($sformatf("host_cmd%0d", i), 64'(log_a[base + i]), 64'(exp10[i]));
        chk("host_hackcnt", 64'(hack_cnt - hb), 1);
        chk("a_no_ovr", 64'(ovr_a), 0);

        // Reset during the read frame of slot 1
        data_a = 12'h444;
        base = nwrt_a;
        wait_nwrt_a("rst_slot1_read", base + 4);
        tick();
        vc = vld_n; hc = hack_cnt;
        rst = 1'b1;
        #1;
        chk("rstmid_ctrl", 64'({wrt_a, hack_a, sd_a, ovr_a, vld_a}), 0);
        chk("rstmid_cmd", 64'(cmd_a), 0);
        chk("rstmid_data", 64'({hdata_a, r0_a, r1_a, r2_a, r3_a}), 0);
        tick();
        rst = 1'b0;
        repeat (15) tick();
        chk("rstmid_novld", 64'(vld_n - vc), 0);
        chk("rstmid_nohack", 64'(hack_cnt - hc), 0);
        chk("rstmid_stale", 64'({hdata_a, r0_a, r1_a, r2_a, r3_a}), 0);
        chk("rstmid_nowrt", 64'(nwrt_a - base), 4);

        // Overrun on instance B
        rst_b = 1'b0;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (sd_b) break;
        end
        chk("ovr_sd", 64'(sd_b), 1);
        en_b = 4'h0;
        chk("ovr_set", 64'(ovr_b), 1);
        chk("ovr_nwrt", 64'(nwrt_b), 8);
        chk("ovr_res", 64'({r0_b, r1_b, r2_b, r3_b}), 'h123123123123);
        repeat (20) tick();
        sdb = sd_cnt_b;
        repeat (80) tick();
        chk("ovr_empty_rate", 64'(sd_cnt_b - sdb), 10);
        chk("ovr_sticky", 64'(ovr_b), 1);
        chk("ovr_no_traffic", 64'({nwrt_b[7:0], vld_b}), 'h80);
        chk("b_no_host", 64'({hack_b, hdata_b}), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, limit 200000 ns");
        $fatal(1);
    end

endmodule
